// File: rtl/stick_pkg.sv
// Shared types and constants for the command-frame receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stick_pkg;

    localparam logic [47:0] DEF_OWN_MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
    localparam logic [15:0] DEF_MAGIC     = 16'hC0DE;
    localparam int          DEF_MAX_CMD   = 16;

    localparam logic [2:0] W_DST_HI = 3'd0;
    localparam logic [2:0] W_DST_LO = 3'd1;
    localparam logic [2:0] W_SRC_HI = 3'd2;
    localparam logic [2:0] W_SRC_LO = 3'd3;
    localparam logic [2:0] W_CTRL   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CTRL,
        ST_CMD,
        ST_DRAIN,
        ST_SKIP,
        ST_COMMIT
    } rx_state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
    } cmd_t;

    typedef struct packed {
        logic [47:0] src;
        logic [7:0]  seq;
        logic [7:0]  n;
    } hdr_t;

endpackage

// File: rtl/eth_cmd_rx_if.sv
// RX word stream from the MAC plus register-write and status outputs.
// Latency: n/a (wiring only).
// Backpressure: rx_rdy from the parser qualifies rx_vld.
interface eth_cmd_rx_if;
    logic [31:0] rx_data;
    logic        rx_vld;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic        rx_rdy;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [23:0] reg_data;
    logic [47:0] peer_mac;
    logic [7:0]  last_seq;
    logic [15:0] frm_ok;
    logic [15:0] frm_drop;

    modport slave (
        input  rx_data, rx_vld, rx_sop, rx_eop, rx_err,
        output rx_rdy, reg_wr, reg_addr, reg_data,
        output peer_mac, last_seq, frm_ok, frm_drop
    );

    modport master (
        output rx_data, rx_vld, rx_sop, rx_eop, rx_err,
        input  rx_rdy, reg_wr, reg_addr, reg_data,
        input  peer_mac, last_seq, frm_ok, frm_drop
    );
endinterface

// File: rtl/cmd_fifo.sv
// Per-frame command buffer: filled while parsing, replayed during commit.
// Latency: read data is combinational from rd pointer; same-cycle write bypasses to read.
// Backpressure: writes beyond len are ignored; reader must not read past wr_cnt.
module cmd_fifo
    import stick_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  cmd_t          wr_dat,
    input  logic          rd_en,
    input  logic [7:0]    len,
    output cmd_t          rd_dat,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          full;
    logic          wr_go;

    assign full  = (8'(wr_ptr) == len);
    assign wr_go = wr_en && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

    // n=1 frames commit the word being written in the same cycle
    assign rd_dat = (wr_go && wr_ptr == rd_ptr) ? wr_dat : mem[rd_ptr[AW-1:0]];
    assign wr_cnt = wr_ptr;
    assign rd_cnt = rd_ptr;
endmodule

// File: rtl/eth_cmd_rx.sv
// Parses command frames from the MAC RX stream and commits their register writes.
// Latency: first reg_wr one cycle after the accepted eop beat, then one write per cycle.
// Backpressure: rx_rdy low only while committing; otherwise one word per cycle.
module eth_cmd_rx
    import stick_pkg::*;
#(
    parameter logic [47:0] OWN_MAC   = DEF_OWN_MAC,
    parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
    parameter logic [15:0] MAGIC     = DEF_MAGIC,
    parameter int          MAX_CMD   = DEF_MAX_CMD
) (
    input  logic         clk,
    input  logic         rst_n,
    eth_cmd_rx_if.slave  bus
);
    localparam int         CW    = $clog2(MAX_CMD) + 1;
    localparam logic [7:0] MAX_N = 8'(MAX_CMD);

    rx_state_t     state, nxt;
    logic [2:0]    widx, widx_d;
    logic          hi_own, hi_own_d;
    hdr_t          hdr_q, hdr_d;
    logic          rx_rdy_q;
    logic [1:0]    drop_inc;
    logic          beat, fail;
    logic          fifo_clr, fifo_wr, fifo_rd, commit_last;
    cmd_t          rd_dat;
    logic [CW-1:0] wr_cnt, rd_cnt;

    logic          reg_wr_q;
    cmd_t          reg_cmd_q;
    logic [47:0]   peer_q;
    logic [7:0]    seq_q;
    logic [15:0]   ok_q, drop_q;

    assign beat = bus.rx_vld && rx_rdy_q;

    always_comb begin
        nxt      = state;
        widx_d   = widx;
        hi_own_d = hi_own;
        hdr_d    = hdr_q;
        drop_inc = 2'd0;
        fail     = 1'b0;
        fifo_clr = 1'b0;
        fifo_wr  = 1'b0;
        if (beat && bus.rx_sop) begin
            // a sop always restarts parsing; an interrupted frame counts as dropped
            if (state inside {ST_HDR, ST_CTRL, ST_CMD, ST_DRAIN}) drop_inc = 2'd1;
            fifo_clr = 1'b1;
            widx_d   = W_DST_LO;
            hi_own_d = (bus.rx_data[15:0] == OWN_MAC[47:32]);
            nxt      = ST_HDR;
            if (bus.rx_err || bus.rx_eop ||
                (!hi_own_d && bus.rx_data[15:0] != BCAST_MAC[47:32])) fail = 1'b1;
        end else if (beat) begin
            case (state)
                ST_HDR: begin
                    widx_d = widx + 3'd1;
                    if (widx == W_DST_LO) begin
                        if (bus.rx_data != (hi_own ? OWN_MAC[31:0] : BCAST_MAC[31:0])) fail = 1'b1;
                    end else if (widx == W_SRC_HI) begin
                        hdr_d.src[47:16] = bus.rx_data;
                    end else begin
                        hdr_d.src[15:0] = bus.rx_data[31:16];
                        widx_d          = W_CTRL;
                        nxt             = ST_CTRL;
                        if (bus.rx_data[15:0] != ETHERTYPE) fail = 1'b1;
                    end
                    if (bus.rx_err || bus.rx_eop) fail = 1'b1;
                end
                ST_CTRL: begin
                    hdr_d.seq = bus.rx_data[15:8];
                    hdr_d.n   = bus.rx_data[7:0];
                    nxt       = ST_CMD;
                    if (bus.rx_err || bus.rx_eop || bus.rx_data[31:16] != MAGIC ||
                        bus.rx_data[7:0] == 8'd0 || bus.rx_data[7:0] > MAX_N) fail = 1'b1;
                end
                ST_CMD: begin
                    fifo_wr = !bus.rx_err;
                    if (8'(wr_cnt) + 8'd1 == hdr_q.n) nxt = bus.rx_eop ? ST_COMMIT : ST_DRAIN;
                    else if (bus.rx_eop)              fail = 1'b1;
                    if (bus.rx_err) fail = 1'b1;
                end
                ST_DRAIN: begin
                    if (bus.rx_err)      fail = 1'b1;
                    else if (bus.rx_eop) nxt  = ST_COMMIT;
                end
                ST_SKIP: begin
                    if (bus.rx_eop) nxt = ST_IDLE;
                end
                default: ;
            endcase
        end
        if (fail) begin
            drop_inc = drop_inc + 2'd1;
            nxt      = bus.rx_eop ? ST_IDLE : ST_SKIP;
        end
        if (state == ST_COMMIT && 8'(rd_cnt) == hdr_q.n) nxt = ST_IDLE;
    end

    // output registers are loaded one edge ahead, so reading starts on the eop edge
    assign fifo_rd     = (nxt == ST_COMMIT);
    assign commit_last = fifo_rd && (8'(rd_cnt) + 8'd1 == hdr_q.n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            widx      <= W_DST_HI;
            hi_own    <= 1'b0;
            hdr_q     <= '0;
            rx_rdy_q  <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_cmd_q <= '0;
            peer_q    <= '0;
            seq_q     <= '0;
            ok_q      <= '0;
            drop_q    <= '0;
        end else begin
            state    <= nxt;
            widx     <= widx_d;
            hi_own   <= hi_own_d;
            hdr_q    <= hdr_d;
            rx_rdy_q <= (nxt != ST_COMMIT);
            reg_wr_q <= fifo_rd;
            drop_q   <= drop_q + 16'(drop_inc);
            if (fifo_rd) reg_cmd_q <= rd_dat;
            if (commit_last) begin
                ok_q   <= ok_q + 16'd1;
                peer_q <= hdr_q.src;
                seq_q  <= hdr_q.seq;
            end
        end
    end

    cmd_fifo #(.DEPTH(MAX_CMD)) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (fifo_clr),
        .wr_en  (fifo_wr),
        .wr_dat (bus.rx_data),
        .rd_en  (fifo_rd),
        .len    (hdr_q.n),
        .rd_dat (rd_dat),
        .wr_cnt (wr_cnt),
        .rd_cnt (rd_cnt)
    );

    assign bus.rx_rdy   = rx_rdy_q;
    assign bus.reg_wr   = reg_wr_q;
    assign bus.reg_addr = reg_cmd_q.addr;
    assign bus.reg_data = reg_cmd_q.data;
    assign bus.peer_mac = peer_q;
    assign bus.last_seq = seq_q;
    assign bus.frm_ok   = ok_q;
    assign bus.frm_drop = drop_q;
endmodule

// File: tb/tb_eth_cmd_rx.sv
// Bench for eth_cmd_rx: directed vector table, hand-written corner sequences,
// and randomized frames scored against a frame-level acceptance model.
module tb_eth_cmd_rx;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_cmd_rx_if bus ();
    eth_cmd_rx #(.MAX_CMD(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [47:0] OWN = 48'h0200_0000_0001;
    localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        logic [15:0] mg;
        logic [7:0]  n;
        int          body;
        int          pad;
        int          err_at;
        int          exp_wr;
        int          exp_low;
    } vec_t;

    int total = 0, bad = 0, cyc = 0, low_cnt = 0, eop_cyc = 0, got_base = 0;
    logic [31:0] fw[$];
    bit          fr[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] m_ok = '0, m_drop = '0;
    logic [7:0]  m_seq = '0;
    logic [47:0] m_peer = '0;
    vec_t        vt[10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.reg_wr) begin
            got_q.push_back({bus.reg_addr, bus.reg_data});
            got_cyc.push_back(cyc);
        end
        if (!bus.rx_rdy) low_cnt <= low_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cmd_word(input int i);
        case (i)
            0:       return 32'h0100_0005;
            1:       return 32'h0200_00AA;
            2:       return 32'h7F12_3456;
            default: return {8'(32'h20 + i), 24'(i * 4369)};
        endcase
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] mg,
                         input logic [7:0] seq, input logic [7:0] n, input int body,
                         input int pad, input bit rnd, input logic [47:0] src);
        fw.delete();
        fr.delete();
        fw.push_back({16'h0, dst[47:32]});
        fw.push_back(dst[31:0]);
        fw.push_back(src[47:16]);
        fw.push_back({src[15:0], et});
        fw.push_back({mg, seq, n});
        for (int i = 0; i < body; i++) fw.push_back(rnd ? 32'($urandom) : cmd_word(i));
        for (int i = 0; i < pad; i++) fw.push_back(32'($urandom));
        for (int i = 0; i < fw.size(); i++) fr.push_back(1'b0);
    endtask

    // Frame-level acceptance rules applied to a complete sop..eop word list.
    task automatic model();
        bit          ok;
        int          len;
        logic [7:0]  n;
        logic [47:0] dst;
        ok  = 1'b1;
        len = fw.size();
        n   = '0;
        foreach (fr[i]) if (fr[i]) ok = 1'b0;
        if (len < 5) ok = 1'b0;
        else begin
            dst = {fw[0][15:0], fw[1]};
            n   = fw[4][7:0];
            if (dst != OWN && dst != BC) ok = 1'b0;
            if (fw[3][15:0] != 16'h88B5 || fw[4][31:16] != 16'hC0DE) ok = 1'b0;
            if (n == 0 || n > 16 || len < 5 + int'(n)) ok = 1'b0;
        end
        if (ok) begin
            m_ok++;
            m_seq  = fw[4][15:8];
            m_peer = {fw[2], fw[3][31:16]};
            for (int i = 0; i < int'(n); i++) exp_q.push_back(fw[5 + i]);
        end else begin
            m_drop++;
        end
    endtask

    task automatic send(input bit with_eop, input int gap);
        int t;
        for (int i = 0; i < fw.size(); i++) begin
            while ($urandom_range(99) < gap) begin
                bus.rx_vld = 1'b0;
                @(negedge clk);
            end
            bus.rx_vld  = 1'b1;
            bus.rx_data = fw[i];
            bus.rx_sop  = (i == 0);
            bus.rx_eop  = with_eop && (i == fw.size() - 1);
            bus.rx_err  = fr[i];
            t = 0;
            while (!bus.rx_rdy && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                total++;
                bad++;
                $display("FAIL rdy_wait: rx_rdy low for %0d cycles, expected high", t);
            end
            @(negedge clk);
            if (bus.rx_eop) eop_cyc = cyc;
        end
        bus.rx_vld = 1'b0;
        bus.rx_sop = 1'b0;
        bus.rx_eop = 1'b0;
        bus.rx_err = 1'b0;
    endtask

    task automatic check_frame(input string nm);
        check({nm, "_nwr"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
            check({nm, "_wr"}, got_q[got_base + i], exp_q[i]);
            check({nm, "_wr_cyc"}, 64'(got_cyc[got_base + i]), 64'(eop_cyc + i));
        end
        check({nm, "_ok"}, bus.frm_ok, m_ok);
        check({nm, "_drop"}, bus.frm_drop, m_drop);
        check({nm, "_seq"}, bus.last_seq, m_seq);
        check({nm, "_peer"}, bus.peer_mac, m_peer);
        exp_q.delete();
        got_base = got_q.size();
    endtask

    initial begin
        int t, low0, r, body;
        logic [47:0] dst;
        logic [15:0] et, mg;
        logic [7:0]  n;

        vt[0] = '{OWN, 16'h88B5, 16'hC0DE, 8'd3, 3, 15, -1, 3, 3};
        vt[1] = '{48'h0200_0000_0002, 16'h88B5, 16'hC0DE, 8'd3, 3, 15, -1, 0, 0};
        vt[2] = '{BC, 16'h88B5, 16'hC0DE, 8'd16, 16, 2, -1, 16, 16};
        vt[3] = '{OWN, 16'h88B5, 16'hC0DE, 8'd17, 17, 0, -1, 0, 0};
        vt[4] = '{OWN, 16'h88B5, 16'hC0DE, 8'd4, 2, 0, -1, 0, 0};
        vt[5] = '{OWN, 16'h88B5, 16'hC0DE, 8'd3, 3, 1, 8, 0, 0};
        vt[6] = '{OWN, 16'h88B5, 16'hC0DE, 8'd0, 0, 3, -1, 0, 0};
        vt[7] = '{OWN, 16'h0800, 16'hC0DE, 8'd1, 1, 0, -1, 0, 0};
        vt[8] = '{OWN, 16'h88B5, 16'hBEEF, 8'd1, 1, 0, -1, 0, 0};
        vt[9] = '{OWN, 16'h88B5, 16'hC0DE, 8'd1, 1, 0, -1, 1, 1};

        bus.rx_vld  = 1'b0;
        bus.rx_sop  = 1'b0;
        bus.rx_eop  = 1'b0;
        bus.rx_err  = 1'b0;
        bus.rx_data = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", bus.rx_rdy, 0);
        check("rst_wr", bus.reg_wr, 0);
        check("rst_ok", bus.frm_ok, 0);
        check("rst_drop", bus.frm_drop, 0);
        check("rst_peer", bus.peer_mac, 0);
        check("rst_cmd", {bus.reg_addr, bus.reg_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.rx_rdy, 1);

        for (int i = 0; i < 10; i++) begin
            build(vt[i].dst, vt[i].et, vt[i].mg, 8'(8'h11 + i), vt[i].n, vt[i].body,
                  vt[i].pad, 1'b0, 48'h0A0B_0C0D_0E0F);
            if (vt[i].err_at >= 0) fr[vt[i].err_at] = 1'b1;
            model();
            low0 = low_cnt;
            send(1'b1, 0);
            repeat (24) @(negedge clk);
            check("vec_nwr_tbl", 64'(got_q.size() - got_base), 64'(vt[i].exp_wr));
            check("vec_rdy_low", 64'(low_cnt - low0), 64'(vt[i].exp_low));
            check_frame("vec");
            if (i == 0) begin
                check("plan_ok", bus.frm_ok, 1);
                check("plan_seq", bus.last_seq, 8'h11);
            end
            if (i == 1) check("plan_drop", bus.frm_drop, 1);
        end

        // single-word frame: sop and eop on w0
        fw.delete(); fr.delete();
        fw.push_back(32'h0000_0200);
        fr.push_back(1'b0);
        model();
        send(1'b1, 0);
        repeat (8) @(negedge clk);
        check_frame("sop_eop_w0");

        // frame A cut by a new sop while storing commands; B must commit alone
        build(OWN, 16'h88B5, 16'hC0DE, 8'h21, 8'd4, 2, 0, 1'b0, 48'h1111_2222_3333);
        send(1'b0, 0);
        m_drop++;
        build(OWN, 16'h88B5, 16'hC0DE, 8'h22, 8'd1, 1, 2, 1'b1, 48'h4444_5555_6666);
        model();
        send(1'b1, 0);
        repeat (8) @(negedge clk);
        check_frame("sop_abort");

        // reset in the middle of a 5-write commit
        build(OWN, 16'h88B5, 16'hC0DE, 8'h55, 8'd5, 5, 0, 1'b1, 48'h7777_8888_9999);
        send(1'b1, 0);
        #1;
        t = 0;
        while (got_q.size() - got_base < 2 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr", bus.reg_wr, 0);
        check("mid_rst_rdy", bus.rx_rdy, 0);
        check("mid_rst_ok", bus.frm_ok, 0);
        check("mid_rst_drop", bus.frm_drop, 0);
        check("mid_rst_seq", bus.last_seq, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_nwr", 64'(got_q.size() - got_base), 2);
        got_base = got_q.size();
        exp_q.delete();
        m_ok = '0; m_drop = '0; m_seq = '0; m_peer = '0;
        build(BC, 16'h88B5, 16'hC0DE, 8'h66, 8'd2, 2, 1, 1'b1, 48'hABCD_EF01_2345);
        model();
        send(1'b1, 0);
        repeat (8) @(negedge clk);
        check_frame("post_rst");

        for (int k = 0; k < 150; k++) begin
            r   = $urandom_range(99);
            dst = (r < 60) ? OWN : (r < 80) ? BC : {16'($urandom), 32'($urandom)};
            et  = ($urandom_range(99) < 90) ? 16'h88B5 : 16'($urandom);
            mg  = ($urandom_range(99) < 90) ? 16'hC0DE : 16'($urandom);
            n   = ($urandom_range(99) < 85) ? 8'($urandom_range(16, 1)) : 8'($urandom_range(20, 0));
            body = ($urandom_range(99) < 85) ? int'(n) : int'($urandom_range(int'(n) + 1, 0));
            build(dst, et, mg, 8'($urandom), n, body, int'($urandom_range(3, 0)), 1'b1,
                  {16'($urandom), 32'($urandom)});
            if ($urandom_range(99) < 8) fr[$urandom_range(fw.size() - 1, 0)] = 1'b1;
            model();
            send(1'b1, 20);
            repeat (24) @(negedge clk);
            check_frame("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
